// File: rtl/mpu_det_seq_if.sv
// Request/result bundle for the sequential determinant engine.
interface mpu_det_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ACC_W  = 48
);
  localparam int unsigned SIZE_W = $clog2(MAX_N + 1);
  localparam int unsigned MAT_W  = MAX_N * MAX_N * DATA_W;

  logic              start;
  logic [SIZE_W-1:0] size;
  logic [MAT_W-1:0]  matrix;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [ACC_W-1:0]  result_wide;
  logic              overflow;
  logic              error;

  modport master (
    output start, size, matrix,
    input  busy, done, result, result_wide, overflow, error
  );

  modport slave (
    input  start, size, matrix,
    output busy, done, result, result_wide, overflow, error
  );
endinterface

// File: rtl/mpu_det_seq.sv
// Sequential signed determinant engine: fraction-free Bareiss elimination with
// row pivoting, one element update per cycle.
module mpu_det_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ACC_W  = 48
) (
  input  logic         clock,
  input  logic         reset_n,
  mpu_det_seq_if.slave bus
);
  localparam int unsigned SIZE_W = $clog2(MAX_N + 1);
  localparam int unsigned IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned PROD_W = 2 * ACC_W;

  typedef enum logic [1:0] {S_IDLE, S_PIVOT, S_ELIM, S_FINISH} state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_m [MAX_N][MAX_N];
  logic signed [ACC_W-1:0]  r_prev;
  logic                     r_neg;
  logic                     r_sing;
  logic                     r_inv;
  logic [SIZE_W-1:0]        r_n;
  logic [IDX_W-1:0]         r_k;
  logic [IDX_W-1:0]         r_r;
  logic [IDX_W-1:0]         r_i;
  logic [IDX_W-1:0]         r_j;
  logic                     r_busy;
  logic                     r_done;
  logic [DATA_W-1:0]        r_result;
  logic [ACC_W-1:0]         r_result_wide;
  logic                     r_ovf;
  logic                     r_err;

  logic [IDX_W-1:0]         w_last;
  logic [IDX_W-1:0]         w_k_nxt;
  logic signed [ACC_W-1:0]  w_piv;
  logic signed [ACC_W-1:0]  w_mkk;
  logic signed [ACC_W-1:0]  w_mij;
  logic signed [ACC_W-1:0]  w_mik;
  logic signed [ACC_W-1:0]  w_mkj;
  logic signed [PROD_W-1:0] w_num;
  logic signed [ACC_W-1:0]  w_upd;
  logic signed [ACC_W-1:0]  w_det;
  logic                     w_ovf;
  logic                     w_start_inv;
  logic                     w_start_fin;

  // Datapath: pivot probe, Bareiss update and final determinant selection
  always_comb begin
    w_last  = IDX_W'(r_n - SIZE_W'(1));
    w_k_nxt = r_k + IDX_W'(1);
    w_piv   = r_m[r_r][r_k];
    w_mkk   = r_m[r_k][r_k];
    w_mij   = r_m[r_i][r_j];
    w_mik   = r_m[r_i][r_k];
    w_mkj   = r_m[r_k][r_j];
    w_num   = PROD_W'(w_mkk) * PROD_W'(w_mij) - PROD_W'(w_mik) * PROD_W'(w_mkj);
    // Exact division by the previous pivot keeps entries integral
    w_upd   = ACC_W'(w_num / PROD_W'(r_prev));

    if (r_inv) begin
      w_det = '0;
    end else if (r_n == SIZE_W'(1)) begin
      w_det = r_m[0][0];
    end else if (r_sing) begin
      w_det = '0;
    end else if (r_neg) begin
      w_det = -r_m[w_last][w_last];
    end else begin
      w_det = r_m[w_last][w_last];
    end
    // Fits DATA_W iff all bits from the DATA_W sign bit upward agree
    w_ovf = !((&w_det[ACC_W-1:DATA_W-1]) || (~|w_det[ACC_W-1:DATA_W-1]));

    w_start_inv = (bus.size == '0) || (bus.size > SIZE_W'(MAX_N));
    w_start_fin = w_start_inv || (bus.size == SIZE_W'(1));
  end

  // Control sequencer and registered results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_prev        <= ACC_W'(1);
      r_neg         <= 1'b0;
      r_sing        <= 1'b0;
      r_inv         <= 1'b0;
      r_n           <= '0;
      r_k           <= '0;
      r_r           <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_result_wide <= '0;
      r_ovf         <= 1'b0;
      r_err         <= 1'b0;
      for (int r = 0; r < int'(MAX_N); r++) begin
        for (int c = 0; c < int'(MAX_N); c++) begin
          r_m[r][c] <= '0;
        end
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n    <= bus.size;
            r_prev <= ACC_W'(1);
            r_neg  <= 1'b0;
            r_sing <= 1'b0;
            r_inv  <= w_start_inv;
            r_k    <= '0;
            r_r    <= '0;
            r_busy <= 1'b1;
            for (int r = 0; r < int'(MAX_N); r++) begin
              for (int c = 0; c < int'(MAX_N); c++) begin
                r_m[r][c] <= ACC_W'($signed(bus.matrix[(r*int'(MAX_N)+c)*int'(DATA_W) +: DATA_W]));
              end
            end
            r_state <= w_start_fin ? S_FINISH : S_PIVOT;
          end
        end

        S_PIVOT: begin
          if (w_piv != '0) begin
            if (r_r != r_k) begin
              for (int c = 0; c < int'(MAX_N); c++) begin
                r_m[r_k][c] <= r_m[r_r][c];
                r_m[r_r][c] <= r_m[r_k][c];
              end
              r_neg <= ~r_neg;
            end
            r_i     <= w_k_nxt;
            r_j     <= w_k_nxt;
            r_state <= S_ELIM;
          end else if (r_r == w_last) begin
            r_sing  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_r <= r_r + IDX_W'(1);
          end
        end

        S_ELIM: begin
          r_m[r_i][r_j] <= w_upd;
          if (r_j == w_last) begin
            if (r_i == w_last) begin
              r_prev  <= w_mkk;
              r_k     <= w_k_nxt;
              r_r     <= w_k_nxt;
              r_state <= (w_k_nxt == w_last) ? S_FINISH : S_PIVOT;
            end else begin
              r_i <= r_i + IDX_W'(1);
              r_j <= w_k_nxt;
            end
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end

        S_FINISH: begin
          r_result_wide <= w_det;
          r_result      <= w_det[DATA_W-1:0];
          r_ovf         <= w_ovf;
          r_err         <= r_inv;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.result_wide = r_result_wide;
  assign bus.overflow    = r_ovf;
  assign bus.error       = r_err;

endmodule

// File: doc/mpu_det_seq.md
# mpu_det_seq

Sequential, parametrised signed-integer determinant engine for square matrices of size 1..MAX_N. It uses fraction-free Bareiss elimination with row pivoting. It replaces the fixed 8-bit, 5x5, free-running cofactor units in the MPU operation set. It takes one flattened matrix per start/done transaction, performs one element update per cycle, and reports both a full-width and a DATA_W-truncated result, plus overflow and error flags.

## Interface
- DATA_W, 8: signed element and truncated-result width.
- MAX_N, 5: largest supported matrix dimension.
- ACC_W, 48: signed working width of every internal matrix element and of result_wide.
- SIZE_W, $clog2(MAX_N+1): width of size.

- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- size  in  SIZE_W  dimension n of the active top-left n×n submatrix.
- matrix  in  MAX_N*MAX_N*DATA_W  row-major, signed; element (r,c) = matrix[(r*MAX_N+c)*DATA_W +: DATA_W]; elements outside n×n ignored.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse; result fields valid and held until next done.
- result  out  DATA_W  low DATA_W bits of the determinant (two's-complement wrap).
- result_wide  out  ACC_W  full determinant.
- overflow  out  1  result_wide outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- error  out  1  size==0 or size>MAX_N.

## Operation
- States: IDLE, PIVOT, ELIM, FINISH.
- IDLE: on a start edge, latch n. Load the n×n elements sign-extended to ACC_W into the work array M. Set prev=1, sign=+1, k=0, r=0.
  - If n<=1 or invalid, go to FINISH.
  - Otherwise, go to PIVOT.
- PIVOT: examine one row r (starting at r=k) per cycle.
  - If M[r][k]!=0 and r!=k: swap rows r and k in the same cycle, negate sign, then go to ELIM with i=j=k+1.
  - If M[r][k]!=0 and r==k: go to ELIM with i=j=k+1, no swap.
  - If M[r][k]==0 and r<n-1: r++.
  - If M[r][k]==0 and r==n-1: the matrix is singular; det=0, go to FINISH.
- ELIM: one element per cycle. M[i][j] <= (M[k][k]*M[i][j] − M[i][k]*M[k][j]) / prev.
  - Form the products and the difference at 2*ACC_W. The division is exact by construction; keep the low ACC_W bits of the quotient.
  - Column k is never written during step k.
  - Order: j runs from k+1 to n-1, then i++ and j resets to k+1.
  - After element (n-1,n-1): prev<=M[k][k], k++, r<=k+1. If the new k==n-1, go to FINISH; otherwise go to PIVOT.
- FINISH: compute det.
  - Invalid size: det=0, error=1.
  - n==1: det=M[0][0].
  - Singular: det=0.
  - Otherwise: det=sign*M[n-1][n-1].
  - Register result_wide, result, overflow and error. Pulse done. Go to IDLE.
- start while busy=1 is ignored. matrix and size may change freely after the start edge.
- ACC_W must cover the Hadamard bound of MAX_N×MAX_N DATA_W matrices. The defaults (8, 5, 48) satisfy this.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, result_wide=0, overflow=0, error=0. Any in-flight transaction is discarded.
- busy rises on the cycle after the accepted start edge. It stays high through the FINISH cycle.
- done=1 and busy=0 appear together one cycle after FINISH. A start in that cycle is accepted.
- Latency L counts edges from the start edge to done visible:
  - L = 1 + Σ_{k=0}^{n-2} (p_k + (n-k-1)^2), where p_k = number of pivot-scan cycles at step k (1 when no swap is needed).
  - If singular at step k: L = 1 + Σ of the completed steps + (n-k).
  - n==1 or invalid size: L = 1.
- Fixed points: n=2 no swap gives L=3; n=5 no swap gives L=35.

## Test plan
- 2×2 [[3,8],[4,6]] -> result_wide=-14, result=-14, overflow=0, error=0; done on cycle 3 after start; busy high cycles 1-2.
- 3×3 [[6,1,1],[4,-2,5],[2,8,7]] -> result_wide=-306, result=-50, overflow=1, L=8.
- Pivot: 3×3 [[0,1,2],[1,0,3],[4,-3,8]] -> one swap, result_wide=-2, L=9. Same matrix with rows 0 and 1 pre-swapped -> +2, L=8.
- 5×5 diag(2,2,2,2,2) -> 32, L=35. -I5 -> -1, L=35. 5×5 with all-zero column 0 -> 0, L=6.
- size=1 with a00=-7 -> -7, L=1. size=0 and size=6 -> error=1, result=0, L=1 each.
- Protocol:
  - start pulsed again mid-transaction -> ignored, original result returned.
  - reset_n low mid-ELIM -> all outputs 0 immediately, no done.
  - Back-to-back start in the done cycle -> second transaction result correct.
